// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the Sobel accelerator controller,
// datapath and testbench.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    LOAD_TAIL,
    PROC,
    DONE
  } ctrl_state_t;

  // Four 8-bit pixels are packed into each memory word.
  function automatic int WORDS_PER_ROW(input int size_row);
    return size_row / 4;
  endfunction

  // Width of a word-column index; never narrower than one bit.
  function automatic int COL_W(input int size_row);
    int w;
    w = $clog2(size_row / 4);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sobel_ctrl.sv
// Frame sequencer for the Sobel accelerator: fills the three-line buffer from
// word memory, then walks each window row and writes result words back.
module sobel_ctrl
  import sobel_pkg::*;
#(
  parameter int SIZE_ROW    = 352,
  parameter int SIZE_COL    = 288,
  parameter int ADDR_W      = 16,
  parameter int RESULT_BASE = 25344
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          finish,
  output logic                          en,
  output logic                          we,
  output logic [ADDR_W-1:0]             addr,
  output logic                          buffer_shift,
  output logic                          buffer_write,
  output logic [COL_W(SIZE_ROW)-1:0]    write_index,
  output logic [COL_W(SIZE_ROW)-1:0]    o_col,
  output logic                          proc_valid
);

  localparam int WPR   = WORDS_PER_ROW(SIZE_ROW);
  localparam int CW    = COL_W(SIZE_ROW);
  localparam int ROW_W = $clog2(SIZE_COL + 1);

  localparam logic [CW-1:0]     COL_LAST     = CW'(WPR - 1);
  localparam logic [CW-1:0]     COL_PRE_LAST = CW'(WPR - 2);
  localparam bit                SINGLE_WORD  = (WPR == 1);
  localparam logic [ROW_W-1:0]  ROWS_FILL    = ROW_W'(3);
  localparam logic [ROW_W-1:0]  ROWS_ALL     = ROW_W'(SIZE_COL);
  // Output row 0 is never written, so the write pointer starts one row in.
  localparam logic [ADDR_W-1:0] WR_START     = ADDR_W'(RESULT_BASE + WPR);

  if ((SIZE_ROW % 4) != 0 || SIZE_ROW < 4) begin : g_bad_row
    $error("sobel_ctrl: SIZE_ROW must be a positive multiple of 4");
  end
  if (SIZE_COL < 3) begin : g_bad_col
    $error("sobel_ctrl: SIZE_COL must be at least 3");
  end
  if (longint'(RESULT_BASE) + longint'(SIZE_COL - 1) * longint'(WPR)
      >= (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("sobel_ctrl: result image does not fit in ADDR_W address bits");
  end

  ctrl_state_t       r_state, w_state;
  logic [CW-1:0]     r_col, w_col;
  logic [ROW_W-1:0]  r_rows, w_rows;
  logic [ADDR_W-1:0] r_rd_ptr, w_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr;

  logic              r_finish, w_finish;
  logic              r_en, w_en;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              r_shift, w_shift;
  logic              r_bwrite, w_bwrite;
  logic              r_pvalid, w_pvalid;
  logic              w_load_last;

  // During LOAD the column counter lags the read column by one, so the first
  // LOAD cycle (no buffer write yet) is recognised by r_bwrite being low.
  assign w_load_last = r_bwrite ? (r_col == COL_PRE_LAST) : SINGLE_WORD;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state  = r_state;
    w_col    = r_col;
    w_rows   = r_rows;
    w_rd_ptr = r_rd_ptr;
    w_wr_ptr = r_wr_ptr;
    w_finish = 1'b0;
    w_en     = 1'b0;
    w_we     = 1'b0;
    w_addr   = '0;
    w_shift  = 1'b0;
    w_bwrite = 1'b0;
    w_pvalid = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state  = SHIFT;
          w_shift  = 1'b1;
          w_col    = '0;
          w_rows   = '0;
          w_rd_ptr = '0;
          w_wr_ptr = WR_START;
        end
      end

      SHIFT: begin
        w_state  = LOAD;
        w_col    = '0;
        w_en     = 1'b1;
        w_addr   = r_rd_ptr;
        w_rd_ptr = r_rd_ptr + 1'b1;
      end

      LOAD: begin
        // The word read last cycle arrives now and is written next cycle.
        w_bwrite = 1'b1;
        if (r_bwrite) w_col = r_col + 1'b1;
        if (w_load_last) begin
          w_state = LOAD_TAIL;
          w_rows  = r_rows + 1'b1;
        end else begin
          w_en     = 1'b1;
          w_addr   = r_rd_ptr;
          w_rd_ptr = r_rd_ptr + 1'b1;
        end
      end

      LOAD_TAIL: begin
        w_col = '0;
        if (r_rows < ROWS_FILL) begin
          w_state = SHIFT;
          w_shift = 1'b1;
        end else begin
          w_state  = PROC;
          w_en     = 1'b1;
          w_we     = 1'b1;
          w_pvalid = 1'b1;
          w_addr   = r_wr_ptr;
          w_wr_ptr = r_wr_ptr + 1'b1;
        end
      end

      PROC: begin
        if (r_col != COL_LAST) begin
          w_col    = r_col + 1'b1;
          w_en     = 1'b1;
          w_we     = 1'b1;
          w_pvalid = 1'b1;
          w_addr   = r_wr_ptr;
          w_wr_ptr = r_wr_ptr + 1'b1;
        end else begin
          w_col = '0;
          if (r_rows == ROWS_ALL) begin
            w_state  = DONE;
            w_finish = 1'b1;
          end else begin
            w_state = SHIFT;
            w_shift = 1'b1;
          end
        end
      end

      DONE: begin
        w_state = IDLE;
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_col    <= '0;
      r_rows   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_finish <= 1'b0;
      r_en     <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_shift  <= 1'b0;
      r_bwrite <= 1'b0;
      r_pvalid <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_col    <= w_col;
      r_rows   <= w_rows;
      r_rd_ptr <= w_rd_ptr;
      r_wr_ptr <= w_wr_ptr;
      r_finish <= w_finish;
      r_en     <= w_en;
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_shift  <= w_shift;
      r_bwrite <= w_bwrite;
      r_pvalid <= w_pvalid;
    end
  end

  assign finish       = r_finish;
  assign en           = r_en;
  assign we           = r_we;
  assign addr         = r_addr;
  assign buffer_shift = r_shift;
  assign buffer_write = r_bwrite;
  assign proc_valid   = r_pvalid;
  assign write_index  = r_col;
  assign o_col        = r_col;

endmodule
